// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first.
// Result flags latch on entry to DONE and hold until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  // One full-subtractor slice, applied to the bit selected by the counter.
  always_comb begin
    a_bit        = a_q[cnt_q];
    b_bit        = b_q[cnt_q];
    d_bit        = a_bit ^ b_bit ^ br_q;
    br_d         = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_d        = res_q;
    res_d[cnt_q] = d_bit;
    ovf_d        = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= borrow_in;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1'b1);
          // The final bit lands directly in the visible result registers.
          if (cnt_q == LAST) begin
            diff_q   <= res_d;
            borrow_q <= br_d;
            ovf_q    <= ovf_d;
            zero_q   <= (res_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed/random cases plus exhaustive WIDTH=2,
// checked against a plain-integer arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, borrow_in;
  logic [7:0] a, b, diff;
  logic       borrow_out, overflow, zero, busy, done;

  logic       rst2, start2, bin2;
  logic [1:0] a2, b2, diff2;
  logic       bo2, ov2, z2, busy2, done2;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero),
    .busy(busy), .done(done)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .borrow_in(bin2),
    .diff(diff2), .borrow_out(bo2), .overflow(ov2), .zero(z2),
    .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int held_d = 0;

  // Arithmetic model: unsigned difference mod 2^w, borrow as sign of the true
  // difference, overflow as the signed result leaving the representable range.
  function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                  output int d, output int bo, output int ov);
    int m, r, sa, sb, sr;
    m  = 1 << w;
    r  = av - bv - bi;
    bo = (r < 0) ? 1 : 0;
    d  = (r + m) % m;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sr = sa - sb - bi;
    ov = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
  endfunction

  task automatic start_op8(input int av, input int bv, input int bi);
    a = 8'(av); b = 8'(bv); borrow_in = 1'(bi); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
  endtask

  task automatic wait_done8(input string name, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      checks++;
      if (diff !== 8'(held_d)) begin
        errors++;
        $display("FAIL %s_hold: diff=%h, required %h", name, diff, 8'(held_d));
      end
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles, required one", name);
    end
  endtask

  task automatic check_result8(input string name, input int av, input int bv, input int bi);
    int ed, ebo, eov;
    ref_sub(8, av, bv, bi, ed, ebo, eov);
    checks++;
    if ({diff, borrow_out, overflow, zero} !== {8'(ed), 1'(ebo), 1'(eov), (ed == 0)}) begin
      errors++;
      $display("FAIL %s_result: diff=%h bo=%b ov=%b z=%b, required diff=%h bo=%0d ov=%0d z=%0d",
               name, diff, borrow_out, overflow, zero, 8'(ed), ebo, eov, (ed == 0));
    end
    held_d = ed;
  endtask

  task automatic do_op8(input string name, input int av, input int bv, input int bi);
    int lat;
    start_op8(av, bv, bi);
    wait_done8(name, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL %s_latency: %0d cycles, required 8", name, lat);
    end
    if (lat > 0) check_result8(name, av, bv, bi);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b busy=%b after done cycle, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    start = 1'b0; start2 = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst2 = 1'b0;
    checks++;
    if ({diff, borrow_out, overflow, zero, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset8: outputs=%b, required all 0", {diff, borrow_out, overflow, zero, busy, done});
    end
    checks++;
    if ({diff2, bo2, ov2, z2, busy2, done2} !== 7'd0) begin
      errors++;
      $display("FAIL reset2: outputs=%b, required all 0", {diff2, bo2, ov2, z2, busy2, done2});
    end
    held_d = 0;
  endtask

  task automatic test_directed;
    do_op8("sub_05_03", 8'h05, 8'h03, 0);
    do_op8("sub_03_05", 8'h03, 8'h05, 0);
    do_op8("sub_80_01", 8'h80, 8'h01, 0);
    do_op8("sub_10_10", 8'h10, 8'h10, 0);
    do_op8("sub_00_00_b", 8'h00, 8'h00, 1);
    do_op8("sub_7f_80_b", 8'h7F, 8'h80, 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      do_op8("random", int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
  endtask

  task automatic test_back_to_back;
    int lat;
    a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h80; b = 8'h01;
    wait_done8("b2b_first", lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL b2b_first_latency: %0d cycles, required 8", lat);
    end
    check_result8("b2b_first", 8'h05, 8'h03, 0);
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    wait_done8("b2b_second", lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL b2b_second_latency: %0d cycles, required 8", lat);
    end
    check_result8("b2b_second", 8'h80, 8'h01, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_restart;
    int pulses, got, ed, ebo, eov;
    ref_sub(8, 8'h3C, 8'h11, 0, ed, ebo, eov);
    start_op8(8'h3C, 8'h11, 0);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'hFF; b = 8'h00; borrow_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; got = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        got = int'(diff);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL restart_pulses: %0d done pulses, required 1", pulses);
    end
    checks++;
    if (got != ed) begin
      errors++;
      $display("FAIL restart_result: diff=%0h, required %0h", got, ed);
    end
    held_d = ed;
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    start_op8(8'h5A, 8'h21, 1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({diff, borrow_out, overflow, zero, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL abort_outputs: outputs=%b, required all 0", {diff, borrow_out, overflow, zero, busy, done});
    end
    held_d = 0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles after reset, required 0", pulses);
    end
    a = 8'h0F; b = 8'h01; borrow_in = 1'b0; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_over_start: %0d active cycles, required 0", pulses);
    end
  endtask

  task automatic test_width2;
    int av, bv, bi, ed, ebo, eov, lat;
    for (int i = 0; i < 32; i++) begin
      av = i & 3; bv = (i >> 2) & 3; bi = (i >> 4) & 1;
      ref_sub(2, av, bv, bi, ed, ebo, eov);
      a2 = 2'(av); b2 = 2'(bv); bin2 = 1'(bi); start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk); #1;
        if (done2 === 1'b1) begin
          lat = n;
          break;
        end
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL w2_latency a=%0d b=%0d bi=%0d: %0d cycles, required 2", av, bv, bi, lat);
      end
      checks++;
      if ({diff2, bo2, ov2} !== {2'(ed), 1'(ebo), 1'(eov)}) begin
        errors++;
        $display("FAIL w2_result a=%0d b=%0d bi=%0d: diff=%0d bo=%b ov=%b, required diff=%0d bo=%0d ov=%0d",
                 av, bv, bi, diff2, bo2, ov2, ed, ebo, eov);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_restart();
    test_reset_mid_run();
    test_width2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
